uc_broadcaster: RTL and testbench

UC_BROADCASTER -- requirements
Module: uc_broadcaster

---
 rtl/uc_broadcaster.sv | 70 +++++++
 tb/tb_uc_broadcaster.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uc_broadcaster.sv
// uc_broadcaster: pops unit-clause literals from the arbiter queue and broadcasts each to all enabled engines.
// Optional build macro UC_BCAST_ZERO_FILTER_EN: discard popped literals equal to 0 instead of broadcasting them.
module uc_broadcaster #(
    parameter int NUM_ENGINE = 4,
    parameter int UC_LENGTH = 1024,
    localparam int LW = $clog2(UC_LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uca_valid,
    input  logic signed [LW-1:0]   uca2eng,
    output logic                   eng2uca_rd,
    input  logic                   conflict,
    input  logic [NUM_ENGINE-1:0]  eng_en,
    output logic signed [LW-1:0]   bc2eng,
    output logic [NUM_ENGINE-1:0]  bc2eng_valid,
    input  logic [NUM_ENGINE-1:0]  eng2bc_ready,
    output logic                   halted,
    output logic [15:0]            bc_count
);
    typedef enum logic [1:0] {IDLE, BCAST, HALT} state_t;
    state_t state;
    logic [NUM_ENGINE-1:0] pending;
    logic [NUM_ENGINE-1:0] remain;
    logic signed [LW-1:0] hold;
    logic done;
    logic pop;
    logic drop;
    logic accept;
    logic empty_load;
    logic [1:0] inc;
    logic [16:0] sum;
`ifdef UC_BCAST_ZERO_FILTER_EN
    assign drop = (uca2eng == '0);
`else
    assign drop = 1'b0;
`endif
    // Pop decision: a new literal may enter when idle or when the current broadcast finishes this cycle
    always_comb begin
        remain = pending & ~eng2bc_ready;
        done = (state == BCAST) && (remain == '0);
        pop = rst && uca_valid && !conflict && ((state == IDLE) || done);
        accept = pop && !drop;
        empty_load = accept && (eng_en == '0);
        inc = {1'b0, done} + {1'b0, empty_load};
        sum = {1'b0, bc_count} + {15'b0, inc};
        eng2uca_rd = pop;
        bc2eng = rst ? hold : '0;
        bc2eng_valid = rst ? pending : '0;
        halted = rst && (state == HALT);
    end
    // Broadcast state machine; conflict abandons any partial broadcast and halts until reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            pending <= '0;
            hold <= '0;
            bc_count <= '0;
        end else if (conflict) begin
            state <= HALT;
            pending <= '0;
            hold <= '0;
        end else if (state != HALT) begin
            bc_count <= sum[16] ? 16'hFFFF : sum[15:0];
            if (accept) hold <= uca2eng;
            pending <= accept ? eng_en : (state == BCAST ? remain : '0);
            state <= ((accept && eng_en != '0) || (state == BCAST && !done)) ? BCAST : IDLE;
        end
    end
endmodule

// File: tb/tb_uc_broadcaster.sv
// tb_uc_broadcaster: directed scoreboard bench for uc_broadcaster (honours UC_BCAST_ZERO_FILTER_EN).
module tb_uc_broadcaster;
    typedef struct packed {
        logic [3:0] eng;
        logic signed [9:0] lit;
    } exp_t;
`ifdef UC_BCAST_ZERO_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    logic uca_valid;
    logic signed [9:0] uca2eng;
    logic eng2uca_rd;
    logic conflict;
    logic [3:0] eng_en;
    logic signed [9:0] bc2eng;
    logic [3:0] bc2eng_valid;
    logic [3:0] eng2bc_ready;
    logic halted;
    logic [15:0] bc_count;
    int checks = 0;
    int failures = 0;
    int exp_count = 0;
    logic signed [9:0] aq[$];
    exp_t sb[$];
    logic rd_s;
    logic [3:0] vld_s;
    logic signed [9:0] bc_s;
    logic halt_s;

    uc_broadcaster dut (
        .clk(clk), .rst(rst), .uca_valid(uca_valid), .uca2eng(uca2eng),
        .eng2uca_rd(eng2uca_rd), .conflict(conflict), .eng_en(eng_en),
        .bc2eng(bc2eng), .bc2eng_valid(bc2eng_valid), .eng2bc_ready(eng2bc_ready),
        .halted(halted), .bc_count(bc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int v);
        aq.push_back(v[9:0]);
        uca_valid = 1'b1;
        uca2eng = aq[0];
    endtask

    task automatic step();
        logic signed [9:0] lit;
        @(negedge clk);
        rd_s = eng2uca_rd;
        vld_s = bc2eng_valid;
        bc_s = bc2eng;
        halt_s = halted;
        chk("rd_without_valid", {31'b0, eng2uca_rd & ~uca_valid}, 0);
        if (eng2uca_rd && aq.size() != 0) begin
            lit = aq.pop_front();
            if (!(FILT && lit == 0)) begin
                exp_count++;
                for (int i = 0; i < 4; i++)
                    if (eng_en[i]) sb.push_back('{eng: 4'(i), lit: lit});
            end
        end
        @(posedge clk);
        #1;
        uca_valid = aq.size() != 0;
        uca2eng = uca_valid ? aq[0] : '0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                if (bc2eng_valid[i] && eng2bc_ready[i]) begin
                    int k;
                    k = -1;
                    for (int j = 0; j < sb.size(); j++)
                        if (k < 0 && sb[j].eng == 4'(i)) k = j;
                    chk($sformatf("deliver_expected_e%0d", i), {31'b0, k >= 0}, 1);
                    if (k >= 0) begin
                        chk($sformatf("deliver_lit_e%0d", i), bc2eng, sb[k].lit);
                        sb.delete(k);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        uca_valid = 1'b1;
        uca2eng = 10'sd5;
        conflict = 1'b0;
        eng_en = 4'hF;
        eng2bc_ready = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd", {31'b0, eng2uca_rd}, 0);
        chk("rst_valid", {28'b0, bc2eng_valid}, 0);
        chk("rst_bc2eng", bc2eng, 0);
        chk("rst_halted", {31'b0, halted}, 0);
        chk("rst_count", {16'b0, bc_count}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        uca_valid = 1'b0;
        uca2eng = '0;
        // three literals back to back
        put(5); put(-3); put(7);
        repeat (3) begin
            step();
            chk("a_rd_consecutive", {31'b0, rd_s}, 1);
        end
        step();
        chk("a_rd_end", {31'b0, rd_s}, 0);
        step();
        chk("a_count", {16'b0, bc_count}, exp_count);
        chk("a_sb_empty", sb.size(), 0);
        // engine 2 stalls five cycles
        eng2bc_ready = 4'b1011;
        put(9); put(11);
        step();
        chk("b_first_pop", {31'b0, rd_s}, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("b_no_pop", {31'b0, rd_s}, 0);
            chk("b_valid", {28'b0, vld_s}, k == 0 ? 4'hF : 4'h4);
        end
        eng2bc_ready = 4'hF;
        step();
        chk("b_pop_after_accept", {31'b0, rd_s}, 1);
        repeat (2) step();
        chk("b_count", {16'b0, bc_count}, exp_count);
        // partial engine enable
        eng_en = 4'b0101;
        put(-12);
        step();
        step();
        chk("c_valid", {28'b0, vld_s}, 4'b0101);
        step();
        chk("c_count", {16'b0, bc_count}, exp_count);
        eng_en = 4'hF;
        // zero literal then 4
        put(0); put(4);
        repeat (4) step();
        chk("d_count", {16'b0, bc_count}, exp_count);
        chk("d_sb_empty", sb.size(), 0);
        // load with no engines enabled
        eng_en = 4'h0;
        put(8);
        step();
        chk("e_pop", {31'b0, rd_s}, 1);
        eng_en = 4'hF;
        step();
        chk("e_valid", {28'b0, vld_s}, 0);
        chk("e_count", {16'b0, bc_count}, exp_count);
        // eng_en changes during broadcast
        eng2bc_ready = 4'h0;
        put(13);
        step();
        eng_en = 4'b0001;
        step();
        chk("f_valid_0", {28'b0, vld_s}, 4'hF);
        step();
        chk("f_valid_1", {28'b0, vld_s}, 4'hF);
        eng_en = 4'hF;
        eng2bc_ready = 4'hF;
        repeat (2) step();
        chk("f_count", {16'b0, bc_count}, exp_count);
        // conflict with only engine 1 pending
        eng2bc_ready = 4'b1101;
        put(21);
        step();
        step();
        conflict = 1'b1;
        put(22);
        step();
        chk("g_rd_conflict", {31'b0, rd_s}, 0);
        chk("g_pending", {28'b0, vld_s}, 4'b0010);
        conflict = 1'b0;
        exp_count--;
        sb.delete();
        step();
        chk("g_halted", {31'b0, halt_s}, 1);
        chk("g_valid", {28'b0, vld_s}, 0);
        chk("g_rd_halt", {31'b0, rd_s}, 0);
        chk("g_count", {16'b0, bc_count}, exp_count);
        step();
        chk("g_still_halted", {31'b0, halted}, 1);
        // reset out of halt, then reset mid-broadcast
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_count = 0;
        eng2bc_ready = 4'h0;
        step();
        chk("h_pop", {31'b0, rd_s}, 1);
        step();
        chk("h_bcast_valid", {28'b0, vld_s}, 4'hF);
        rst = 1'b0;
        step();
        chk("h_rst_rd", {31'b0, rd_s}, 0);
        chk("h_rst_valid", {28'b0, vld_s}, 0);
        chk("h_rst_bc2eng", bc_s, 0);
        chk("h_rst_halted", {31'b0, halt_s}, 0);
        rst = 1'b1;
        exp_count = 0;
        sb.delete();
        step();
        chk("h_idle_valid", {28'b0, vld_s}, 0);
        chk("h_idle_bc2eng", bc_s, 0);
        chk("h_idle_halted", {31'b0, halt_s}, 0);
        chk("h_idle_rd", {31'b0, rd_s}, 0);
        chk("h_idle_count", {16'b0, bc_count}, 0);
        eng2bc_ready = 4'hF;
        put(23);
        repeat (3) step();
        chk("h_count", {16'b0, bc_count}, exp_count);
        chk("h_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
